// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: sole driver of the regfile write port, merging ALU results with buffered load responses.
// Optional operand bypass from the registered write port is enabled by defining WB_BYPASS_EN.
module regfile_wb_ctrl #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [4:0]                alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      ld_issue,
  input  logic [4:0]                ld_issue_rd,
  input  logic                      ld_rsp_valid,
  output logic                      ld_rsp_ready,
  input  logic [4:0]                ld_rsp_rd,
  input  logic [XLEN-1:0]           ld_rsp_data,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  input  logic [XLEN-1:0]           rf_rd1,
  input  logic [XLEN-1:0]           rf_rd2,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic [XLEN-1:0]           byp_rd1,
  output logic [XLEN-1:0]           byp_rd2,
  output logic                      we,
  output logic [4:0]                rd,
  output logic [XLEN-1:0]           wd,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      lq_rd   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;

  logic            push;
  logic            sel_ld;
  logic            sel_alu;
  logic            sel_any;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  assign ld_rsp_ready = (lq_count != CW'(LQ_DEPTH));
  assign alu_ready    = (lq_count == '0);
  assign push         = ld_rsp_valid & ld_rsp_ready;

  // Buffered loads always win; the ALU only gets the port when the queue is empty.
  assign sel_ld   = (lq_count != '0);
  assign sel_alu  = !sel_ld && alu_valid;
  assign sel_any  = sel_ld | sel_alu;
  assign sel_rd   = sel_ld ? lq_rd[rd_ptr]   : alu_rd;
  assign sel_data = sel_ld ? lq_data[rd_ptr] : alu_data;

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[wr_ptr]   <= ld_rsp_rd;
      lq_data[wr_ptr] <= ld_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (sel_ld) rd_ptr <= rd_ptr + PW'(1);
      case ({push, sel_ld})
        2'b10:   lq_count <= lq_count + CW'(1);
        2'b01:   lq_count <= lq_count - CW'(1);
        default: lq_count <= lq_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we <= 1'b0;
      rd <= '0;
      wd <= '0;
    end else begin
      we <= sel_any && (sel_rd != 5'd0);
      if (sel_any) begin
        rd <= sel_rd;
        wd <= sel_data;
      end
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the register pending.
  always_comb begin
    pending_nxt = pending;
    if (sel_ld) pending_nxt[sel_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_nxt;
  end

  logic hit1;
  logic hit2;
  assign hit1 = we && (rd == rs1) && (rs1 != 5'd0);
  assign hit2 = we && (rd == rs2) && (rs2 != 5'd0);

`ifdef WB_BYPASS_EN
  assign rs1_busy = pending[rs1] && (rs1 != 5'd0);
  assign rs2_busy = pending[rs2] && (rs2 != 5'd0);
  assign byp_rd1  = hit1 ? wd : rf_rd1;
  assign byp_rd2  = hit2 ? wd : rf_rd2;
`else
  // Without forwarding, decode waits one cycle for the in-flight write to land.
  assign rs1_busy = (pending[rs1] && (rs1 != 5'd0)) || hit1;
  assign rs2_busy = (pending[rs2] && (rs2 != 5'd0)) || hit2;
  assign byp_rd1  = rf_rd1;
  assign byp_rd2  = rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl with a behavioural regfile on the write port.
// Expected values follow WB_BYPASS_EN when the macro is defined for the build.
module tb_regfile_wb_ctrl;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [4:0]  ld_rsp_rd;
  logic [31:0] ld_rsp_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] byp_rd1;
  logic [31:0] byp_rd2;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [1:0]  lq_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_mem [32];

  regfile_wb_ctrl #(.XLEN(32), .LQ_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_ready(ld_rsp_ready),
    .ld_rsp_rd(ld_rsp_rd), .ld_rsp_data(ld_rsp_data),
    .rs1(rs1), .rs2(rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
    .we(we), .rd(rd), .wd(wd), .lq_count(lq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (we && rd != 5'd0) rf_mem[rd] <= wd;
  assign rf_rd1 = rf_mem[rs1];
  assign rf_rd2 = rf_mem[rs2];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_rsp_valid = 0; ld_rsp_rd = 0; ld_rsp_data = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); rs1 = 5'd5; rs2 = 5'd0;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    #2;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b exp 0", we); end
    checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d exp 0", rd); end
    checks++; if (wd !== 32'd0) begin errors++; $display("FAIL reset_wd got %h exp 0", wd); end
    checks++; if (lq_count !== 2'd0) begin errors++; $display("FAIL reset_lq_count got %0d exp 0", lq_count); end
    checks++; if (ld_rsp_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got ld=%0b alu=%0b exp 1 1", ld_rsp_ready, alu_ready); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", rs1_busy); end
    @(negedge clk); reset_n = 1;
    cyc();
  endtask

  task automatic test_alu_write();
    rs1 = 5'd5;
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %0b exp 1", alu_ready); end
    cyc(); idle(); #1;
    checks++; if (we !== 1'b1 || rd !== 5'd5 || wd !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write got we=%0b rd=%0d wd=%h exp 1 5 deadbeef", we, rd, wd); end
    checks++; if (rs1_busy !== !BYP) begin errors++; $display("FAIL alu_inflight_busy got %0b exp %0b", rs1_busy, !BYP); end
    checks++; if (byp_rd1 !== (BYP ? 32'hDEADBEEF : 32'd0)) begin errors++; $display("FAIL alu_inflight_byp got %h", byp_rd1); end
    cyc();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL alu_we_drop got %0b exp 0", we); end
    checks++; if (byp_rd1 !== 32'hDEADBEEF || rs1_busy !== 1'b0) begin errors++; $display("FAIL alu_commit got byp=%h busy=%0b exp deadbeef 0", byp_rd1, rs1_busy); end
  endtask

  task automatic test_rd0();
    rs1 = 5'd0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %0b exp 1", alu_ready); end
    cyc(); idle(); #1;
    checks++; if (we !== 1'b0 || rd !== 5'd0) begin errors++; $display("FAIL rd0_we got we=%0b rd=%0d exp 0 0", we, rd); end
    cyc();
    checks++; if (byp_rd1 !== 32'd0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL rd0_x0 got byp=%h busy=%0b exp 0 0", byp_rd1, rs1_busy); end
  endtask

  task automatic test_scoreboard();
    rs1 = 5'd7;
    ld_issue = 1; ld_issue_rd = 5'd7;
    cyc(); idle(); #1;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_set got %0b exp 1", rs1_busy); end
    cyc(); cyc();
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_busy_hold got %0b exp 1", rs1_busy); end
    ld_rsp_valid = 1; ld_rsp_rd = 5'd7; ld_rsp_data = 32'hCAFE;
    #1;
    checks++; if (ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL sb_rsp_ready got %0b exp 1", ld_rsp_ready); end
    cyc(); idle(); #1;
    checks++; if (lq_count !== 2'd1 || we !== 1'b0 || rs1_busy !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL sb_push got cnt=%0d we=%0b busy=%0b alu_rdy=%0b exp 1 0 1 0", lq_count, we, rs1_busy, alu_ready); end
    cyc();
    checks++; if (lq_count !== 2'd0 || we !== 1'b1 || rd !== 5'd7 || wd !== 32'hCAFE) begin errors++; $display("FAIL sb_pop got cnt=%0d we=%0b rd=%0d wd=%h exp 0 1 7 cafe", lq_count, we, rd, wd); end
    checks++; if (rs1_busy !== !BYP) begin errors++; $display("FAIL sb_clear_busy got %0b exp %0b", rs1_busy, !BYP); end
    cyc();
    checks++; if (rs1_busy !== 1'b0 || byp_rd1 !== 32'hCAFE) begin errors++; $display("FAIL sb_done got busy=%0b byp=%h exp 0 cafe", rs1_busy, byp_rd1); end
  endtask

  task automatic test_back_to_back();
    // Queue pops whenever non-empty, so occupancy tops out at one entry here.
    rs1 = 5'd0;
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h55;
    ld_rsp_valid = 1; ld_rsp_rd = 5'd3; ld_rsp_data = 32'hA;
    cyc();
    checks++; if (we !== 1'b1 || rd !== 5'd10 || wd !== 32'h55 || lq_count !== 2'd1) begin errors++; $display("FAIL b2b_e1 got we=%0b rd=%0d wd=%h cnt=%0d exp 1 10 55 1", we, rd, wd, lq_count); end
    ld_rsp_rd = 5'd4; ld_rsp_data = 32'hB;
    #1;
    checks++; if (alu_ready !== 1'b0 || ld_rsp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got alu=%0b ld=%0b exp 0 1", alu_ready, ld_rsp_ready); end
    cyc();
    checks++; if (we !== 1'b1 || rd !== 5'd3 || wd !== 32'hA || lq_count !== 2'd1) begin errors++; $display("FAIL b2b_e2 got we=%0b rd=%0d wd=%h cnt=%0d exp 1 3 a 1", we, rd, wd, lq_count); end
    ld_rsp_rd = 5'd5; ld_rsp_data = 32'hC;
    #1;
    checks++; if (ld_rsp_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready2 got ld=%0b alu=%0b exp 1 0", ld_rsp_ready, alu_ready); end
    cyc();
    ld_rsp_valid = 0;
    checks++; if (we !== 1'b1 || rd !== 5'd4 || wd !== 32'hB || lq_count !== 2'd1) begin errors++; $display("FAIL b2b_e3 got we=%0b rd=%0d wd=%h cnt=%0d exp 1 4 b 1", we, rd, wd, lq_count); end
    cyc();
    checks++; if (we !== 1'b1 || rd !== 5'd5 || wd !== 32'hC || lq_count !== 2'd0) begin errors++; $display("FAIL b2b_e4 got we=%0b rd=%0d wd=%h cnt=%0d exp 1 5 c 0", we, rd, wd, lq_count); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL b2b_alu_ready got %0b exp 1", alu_ready); end
    cyc(); idle();
    checks++; if (we !== 1'b1 || rd !== 5'd10 || wd !== 32'h55) begin errors++; $display("FAIL b2b_e5 got we=%0b rd=%0d wd=%h exp 1 10 55", we, rd, wd); end
    cyc();
  endtask

  task automatic test_collision();
    rs1 = 5'd9;
    ld_issue = 1; ld_issue_rd = 5'd9;
    cyc(); idle();
    ld_rsp_valid = 1; ld_rsp_rd = 5'd9; ld_rsp_data = 32'h99;
    cyc(); idle();
    ld_issue = 1; ld_issue_rd = 5'd9;
    cyc(); idle(); #1;
    checks++; if (we !== 1'b1 || rd !== 5'd9 || wd !== 32'h99) begin errors++; $display("FAIL coll_write got we=%0b rd=%0d wd=%h exp 1 9 99", we, rd, wd); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL coll_busy got %0b exp 1", rs1_busy); end
    cyc();
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL coll_pending got %0b exp 1", rs1_busy); end
  endtask

  task automatic test_reset_midop();
    rs1 = 5'd3;
    ld_issue = 1; ld_issue_rd = 5'd3;
    ld_rsp_valid = 1; ld_rsp_rd = 5'd8; ld_rsp_data = 32'h77;
    cyc(); idle(); #1;
    checks++; if (lq_count !== 2'd1 || rs1_busy !== 1'b1) begin errors++; $display("FAIL mid_setup got cnt=%0d busy=%0b exp 1 1", lq_count, rs1_busy); end
    reset_n = 0;
    #1;
    checks++; if (we !== 1'b0 || lq_count !== 2'd0 || rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_reset got we=%0b cnt=%0d busy=%0b exp 0 0 0", we, lq_count, rs1_busy); end
    rs1 = 5'd9;
    #1;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_pend9 got %0b exp 0", rs1_busy); end
    @(negedge clk); reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (we !== 1'b0 || lq_count !== 2'd0) begin errors++; $display("FAIL mid_after%0d got we=%0b cnt=%0d exp 0 0", i, we, lq_count); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_rd0();
    test_scoreboard();
    test_back_to_back();
    test_collision();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
